// File: rtl/arm_isa_pkg.sv
// -----------------------------------------------------------------------------
// arm_isa_pkg
// Shared ARM ISA constants for the instruction encoder:
//   - instruction class codes presented on instr_class
//   - the "always" condition code
//   - shift type and data-processing opcode encodings
//   - encoder FSM state type and the captured-request field bundle
// -----------------------------------------------------------------------------
package arm_isa_pkg;

    // Instruction classes
    localparam logic [2:0] CLS_DP_REG = 3'b000;
    localparam logic [2:0] CLS_DP_IMM = 3'b001;
    localparam logic [2:0] CLS_LS_IMM = 3'b010;
    localparam logic [2:0] CLS_LS_REG = 3'b011;
    localparam logic [2:0] CLS_BRANCH = 3'b101;

    // Condition code "always"
    localparam logic [3:0] COND_AL = 4'hE;

    // Shift types
    localparam logic [1:0] SHIFT_LSL = 2'b00;
    localparam logic [1:0] SHIFT_LSR = 2'b01;
    localparam logic [1:0] SHIFT_ASR = 2'b10;
    localparam logic [1:0] SHIFT_ROR = 2'b11;

    // Data-processing opcodes
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_RSB = 4'b0011;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_RSC = 4'b0111;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_TEQ = 4'b1001;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_CMN = 4'b1011;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_BIC = 4'b1110;
    localparam logic [3:0] OP_MVN = 4'b1111;

    // Encoder FSM states
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_SEARCH = 1'b1
    } enc_state_t;

    // All request fields, captured together on the accepting edge
    typedef struct packed {
        logic [2:0]  cls;
        logic [3:0]  rd;
        logic [3:0]  rn;
        logic [3:0]  rm;
        logic [3:0]  rs;
        logic [3:0]  opcode;
        logic        set_flags;
        logic [1:0]  shift;
        logic [4:0]  shift_amount;
        logic        use_rs;
        logic [31:0] imm32;
        logic        p_bit;
        logic        u_bit;
        logic        b_bit;
        logic        w_bit;
        logic        l_bit;
        logic [11:0] offset_12;
        logic        branch_with_link;
        logic [23:0] signed_immed_24;
    } enc_fields_t;

endpackage : arm_isa_pkg

// File: rtl/imm_rotation_check.sv
// -----------------------------------------------------------------------------
// imm_rotation_check
// Combinational test of one candidate rotation for an ARM data-processing
// immediate: rotating imm32 left by 2*rot must leave only the low byte set.
// Ports:
//   i_imm32  in  32  value to be represented
//   i_rot    in   4  candidate rotate_imm
//   o_fits   out  1  value is representable with this rotation
//   o_imm8   out  8  imm8 field for this rotation (meaningful when o_fits)
// -----------------------------------------------------------------------------
module imm_rotation_check (
    input  logic [31:0] i_imm32,
    input  logic [3:0]  i_rot,
    output logic        o_fits,
    output logic [7:0]  o_imm8
);

    logic [63:0] w_dbl;
    logic [31:0] w_rol;

    // Shifting the doubled word left and keeping the upper half is a rotate
    // left; a shift of zero degenerates cleanly to the unrotated value.
    assign w_dbl  = {i_imm32, i_imm32} << {i_rot, 1'b0};
    assign w_rol  = w_dbl[63:32];
    assign o_fits = (w_rol[31:8] == 24'd0);
    assign o_imm8 = w_rol[7:0];

endmodule : imm_rotation_check

// File: rtl/instruction_encoder.sv
// -----------------------------------------------------------------------------
// instruction_encoder
// Packs decoded ARM fields into a 32-bit instruction word (DP-reg, DP-imm,
// LS-imm, LS-reg, branch). All request fields are captured on the accepting
// edge; the word is produced one edge later, except DP-imm, which searches
// rotate_imm one value per cycle and finishes on the first fitting rotation.
//
// Handshake: start is sampled only while busy=0. busy is high only while a
// DP-imm search runs. Completion is a one-cycle valid pulse (error alongside
// it for unsupported classes or an unrepresentable immediate); instruction
// holds until the next completion.
//
// Build option: define ENCODER_FAST_IMM_EN to check all 16 rotations in
// parallel so DP-imm also completes one edge after acceptance.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start / busy        request / search in progress
//   instr_class         class code (see arm_isa_pkg)
//   rd, rn, rm, rs      register fields
//   opcode, set_flags   DP opcode and S bit
//   shift, shift_amount shift type and immediate amount
//   use_rs              register-specified shift for DP-reg
//   imm32               DP-imm operand value
//   p/u/b/w/l_bit       load/store control bits
//   offset_12           LS-imm offset
//   branch_with_link    branch L bit
//   signed_immed_24     branch offset
//   instruction         encoded word
//   valid, error        completion pulse and its error flag
// -----------------------------------------------------------------------------
module instruction_encoder
    import arm_isa_pkg::*;
#(
    parameter logic [3:0] COND = COND_AL
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    input  logic [2:0]  instr_class,
    input  logic [3:0]  rd,
    input  logic [3:0]  rn,
    input  logic [3:0]  rm,
    input  logic [3:0]  rs,
    input  logic [3:0]  opcode,
    input  logic        set_flags,
    input  logic [1:0]  shift,
    input  logic [4:0]  shift_amount,
    input  logic        use_rs,
    input  logic [31:0] imm32,
    input  logic        p_bit,
    input  logic        u_bit,
    input  logic        b_bit,
    input  logic        w_bit,
    input  logic        l_bit,
    input  logic [11:0] offset_12,
    input  logic        branch_with_link,
    input  logic [23:0] signed_immed_24,
    output logic [31:0] instruction,
    output logic        valid,
    output logic        error
);

    enc_state_t  r_state;
    enc_fields_t r_fld;
    logic [3:0]  r_rot;
    logic        r_pend;
    logic        r_busy;
    logic        r_valid;
    logic        r_error;
    logic [31:0] r_instruction;

    enc_fields_t w_in;
    logic        w_fit;
    logic [3:0]  w_rot;
    logic [7:0]  w_imm8;
    logic [31:0] w_word;
    logic        w_bad;

    assign w_in = '{
        cls:              instr_class,
        rd:               rd,
        rn:               rn,
        rm:               rm,
        rs:               rs,
        opcode:           opcode,
        set_flags:        set_flags,
        shift:            shift,
        shift_amount:     shift_amount,
        use_rs:           use_rs,
        imm32:            imm32,
        p_bit:            p_bit,
        u_bit:            u_bit,
        b_bit:            b_bit,
        w_bit:            w_bit,
        l_bit:            l_bit,
        offset_12:        offset_12,
        branch_with_link: branch_with_link,
        signed_immed_24:  signed_immed_24
    };

`ifdef ENCODER_FAST_IMM_EN
    logic [15:0] w_fits_vec;
    logic [7:0]  w_imm8_vec [16];

    for (genvar g = 0; g < 16; g++) begin : g_rot
        imm_rotation_check u_chk (
            .i_imm32 (r_fld.imm32),
            .i_rot   (4'(g)),
            .o_fits  (w_fits_vec[g]),
            .o_imm8  (w_imm8_vec[g])
        );
    end

    // Walk from the largest rotation down so the smallest fitting one is
    // the last to write, i.e. it has priority.
    always_comb begin
        w_fit  = 1'b0;
        w_rot  = 4'd0;
        w_imm8 = 8'd0;
        for (int i = 15; i >= 0; i--) begin
            if (w_fits_vec[i]) begin
                w_fit  = 1'b1;
                w_rot  = 4'(i);
                w_imm8 = w_imm8_vec[i];
            end
        end
    end
`else
    // One checker, stepped through rotations by r_rot during SEARCH.
    imm_rotation_check u_chk (
        .i_imm32 (r_fld.imm32),
        .i_rot   (r_rot),
        .o_fits  (w_fit),
        .o_imm8  (w_imm8)
    );
    assign w_rot = r_rot;
`endif

    // Word for the captured request. An unrepresentable DP-imm or an
    // unsupported class yields zero with w_bad set.
    always_comb begin
        w_word = 32'd0;
        w_bad  = 1'b0;
        case (r_fld.cls)
            CLS_DP_REG: begin
                w_word = {COND, 3'b000, r_fld.opcode, r_fld.set_flags,
                          r_fld.rn, r_fld.rd,
                          (r_fld.use_rs ? {r_fld.rs, 1'b0} : r_fld.shift_amount),
                          r_fld.shift, r_fld.use_rs, r_fld.rm};
            end
            CLS_DP_IMM: begin
                w_bad = !w_fit;
                if (w_fit) begin
                    w_word = {COND, 3'b001, r_fld.opcode, r_fld.set_flags,
                              r_fld.rn, r_fld.rd, w_rot, w_imm8};
                end
            end
            CLS_LS_IMM: begin
                w_word = {COND, 3'b010, r_fld.p_bit, r_fld.u_bit, r_fld.b_bit,
                          r_fld.w_bit, r_fld.l_bit, r_fld.rn, r_fld.rd,
                          r_fld.offset_12};
            end
            CLS_LS_REG: begin
                w_word = {COND, 3'b011, r_fld.p_bit, r_fld.u_bit, r_fld.b_bit,
                          r_fld.w_bit, r_fld.l_bit, r_fld.rn, r_fld.rd,
                          r_fld.shift_amount, r_fld.shift, 1'b0, r_fld.rm};
            end
            CLS_BRANCH: begin
                w_word = {COND, 3'b101, r_fld.branch_with_link,
                          r_fld.signed_immed_24};
            end
            default: begin
                w_bad = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_fld         <= '0;
            r_rot         <= 4'd0;
            r_pend        <= 1'b0;
            r_busy        <= 1'b0;
            r_valid       <= 1'b0;
            r_error       <= 1'b0;
            r_instruction <= 32'd0;
        end else begin
            r_valid <= 1'b0;
            r_error <= 1'b0;
            r_pend  <= 1'b0;

            // Single-cycle classes: captured last edge, emitted now.
            if (r_pend) begin
                r_valid       <= 1'b1;
                r_error       <= w_bad;
                r_instruction <= w_word;
            end

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_fld <= w_in;
`ifdef ENCODER_FAST_IMM_EN
                        r_pend <= 1'b1;
`else
                        if (instr_class == CLS_DP_IMM) begin
                            r_state <= ST_SEARCH;
                            r_busy  <= 1'b1;
                            r_rot   <= 4'd0;
                        end else begin
                            r_pend <= 1'b1;
                        end
`endif
                    end
                end
                ST_SEARCH: begin
                    if (w_fit || (r_rot == 4'd15)) begin
                        r_valid       <= 1'b1;
                        r_error       <= !w_fit;
                        r_instruction <= w_word;
                        r_busy        <= 1'b0;
                        r_rot         <= 4'd0;
                        r_state       <= ST_IDLE;
                    end else begin
                        r_rot <= r_rot + 4'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign valid       = r_valid;
    assign error       = r_error;
    assign instruction = r_instruction;

endmodule : instruction_encoder

// File: doc/instruction_encoder.md
Name: instruction_encoder

Overview:
- Reverse of the decode path: packs decoded ARM fields into a 32-bit instruction word. Used by the self-check bench and the boot-ROM builder to emit instructions into instruction memory.
- Supports the same five classes the core executes: DP-reg, DP-imm, LS-imm, LS-reg and branch.
- For DP-imm, an arbitrary imm32 is converted to rotate_imm/imm8 by an iterative search, one rotation per cycle. Start/valid handshake.

Parameters:
- COND, 4'hE, condition field placed in [31:28] of every emitted word.

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- start  in  1  request; accepted only when busy=0
- busy  out  1  high from the accepting edge until valid
- instr_class  in  3  000 DP-reg, 001 DP-imm, 010 LS-imm, 011 LS-reg, 101 branch
- rd, rn, rm, rs  in  4 each  register fields
- opcode  in  4  DP opcode
- set_flags  in  1  S bit [20] for DP classes
- shift  in  2  shift type
- shift_amount  in  5  immediate shift
- use_rs  in  1  DP-reg register-specified shift
- imm32  in  32  DP-imm operand value
- p_bit, u_bit, b_bit, w_bit, l_bit  in  1 each  LS bits [24:20]
- offset_12  in  12  LS-imm offset
- branch_with_link  in  1  L bit [24] for branch
- signed_immed_24  in  24  branch offset
- instruction  out  32  encoded word
- valid  out  1  one-cycle completion pulse
- error  out  1  one-cycle, coincident with valid

Behaviour:
- Reset: instruction=0, valid=0, error=0, busy=0, FSM=IDLE, rot counter=0. Reset mid-search aborts with no valid pulse.
- FSM states: IDLE, SEARCH.
- IDLE, start=1 at edge E0: all inputs are captured into registers; later input changes are ignored. Class 001 -> SEARCH with busy=1. Any other class completes at E1.
- start while busy=1 is ignored; it is not queued.
- SEARCH tests rotation r=0..15 on the captured imm32, r starting at 0 in the cycle after E0.
  - fits(r) is true when rol(imm32, 2r)[31:8]==0; then imm8 = rol(imm32, 2r)[7:0] and rotate_imm = r.
  - The smallest fitting r wins. Completion at E(r+1), returning to IDLE.
  - If no r fits, completion at E16 with error=1 and instruction=0.
- Completion: valid=1 for exactly one cycle and busy=0 from that edge. instruction holds its value until the next completion.
- Encodings ([31:28]=COND throughout):
  - DP-reg: [27:25]=000, [24:21]=opcode, [20]=S, [19:16]=rn, [15:12]=rd, [3:0]=rm, [6:5]=shift.
    - use_rs=1: [11:8]=rs, [7]=0, [4]=1.
    - use_rs=0: [11:7]=shift_amount, [4]=0.
  - DP-imm: [27:25]=001, opcode, S, rn, rd, [11:8]=rotate_imm, [7:0]=imm8.
  - LS-imm: [27:25]=010, [24:20]=P U B W L, rn, rd, [11:0]=offset_12.
  - LS-reg: [27:25]=011, P U B W L, rn, rd, [11:7]=shift_amount, [6:5]=shift, [4]=0, [3:0]=rm.
  - Branch: [27:25]=101, [24]=branch_with_link, [23:0]=signed_immed_24.
- Unsupported class (100, 110, 111): valid=1, error=1, instruction=0 at E1.
- Back-to-back: start may be asserted in the same cycle valid is high; it is accepted at that edge.

Optional Feature:
- ENCODER_FAST_IMM_EN defined: all 16 rotations are checked in parallel with a priority pick of the smallest r. DP-imm then completes at E1, including the error case. SEARCH is never entered and busy never rises for more than zero cycles.
- Undefined: iterative search as above.

Decomposition:
- Package arm_isa_pkg holds:
  - class codes (CLS_DP_REG=3'b000 etc.)
  - COND_AL=4'hE
  - shift types LSL/LSR/ASR/ROR
  - DP opcode constants
- Sub-module imm_rotation_check (combinational): inputs imm32 and r[3:0]; outputs fits and imm8. Instantiated once in iterative mode and 16 times under ENCODER_FAST_IMM_EN.

Test Plan:
- DP-imm ADD r1,r2,#0xFF (opcode 0100, S=0) -> valid at E1, instruction 0xE28210FF, error=0.
- DP-imm MOV r0,#0xFF000000 (opcode 1101, rn=0) -> busy E0..E5, valid at E5 (r=4), instruction 0xE3A004FF. With ENCODER_FAST_IMM_EN: valid at E1.
- DP-imm imm32=0x00000101 -> valid+error at E16, instruction 0. Then reset asserted at E3 of a repeat request -> no valid, busy=0 after E3. A start during busy is ignored.
- LDR r3,[r4,#8] (P=1 U=1 B=0 W=0 L=1) -> 0xE5943008 at E1. DP-reg ADD r0,r1,r2,LSL #3 -> 0xE0810182.
- BL with imm24=0x000010 -> 0xEB000010. instr_class=3'b110 -> valid+error, instruction 0.
- Back-to-back: start held high across two requests -> second request is accepted on the first request's valid edge, with no lost or duplicated pulse.
